uart_tx_fifo_drain: RTL and testbench

//   Downstream consumer of the 8-bit byte FIFO. Pops one byte whenever the FIFO
//   is non-empty and transmission is enabled, then serialises it as an 8N1-style

---
 rtl/uart_tx_fifo_drain.sv | 159 +++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain
//   Pulls bytes out of an upstream show-ahead byte FIFO and sends each one as
//   a UART frame on tx: one start bit (low), DATA_SIZE data bits LSB first,
//   then STOP_BITS stop bits (high). One pop per frame. A pop happens only in
//   IDLE, when the FIFO is non-empty and tx_enable is high.
//
// Parameters
//   DATA_SIZE     data bits per frame (matches the FIFO word width)
//   CLKS_PER_BIT  clk cycles per bit period (>= 2)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   tx_enable   1 = new frames may start; 0 = finish current frame, then idle
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO head word (combinational FIFO output)
//   fifo_rd     pop strobe to the FIFO (combinational, one cycle per byte)
//   tx          registered serial line, idle high
//   tx_busy     high whenever a frame is in progress
//   tx_done     registered one-cycle pulse in the first IDLE cycle after a frame
// -----------------------------------------------------------------------------
module uart_tx_fifo_drain #(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_enable,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // The bit counter indexes data bits and also stop bits (at most 2).
  localparam int BIT_W  = (DATA_SIZE > 2) ? $clog2(DATA_SIZE) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_SIZE - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [BAUD_W-1:0]      baud_reg, baud_next;
  logic [BIT_W-1:0]       bit_reg, bit_next;
  logic [DATA_SIZE-1:0]   shift_reg, shift_next;
  logic                   tx_reg, tx_next;
  logic                   tx_done_reg, tx_done_next;
  logic                   baud_end;

  // Pop only from IDLE; reset is included so no pop is issued while
  // the block is being reset, even if the FIFO has data.
  assign fifo_rd  = (state_reg == IDLE) && !fifo_empty && tx_enable && !reset;
  assign baud_end = (baud_reg == BAUD_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      tx_done_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      tx_done_reg <= tx_done_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (fifo_rd) begin
          // The head word is captured on the pop edge, so later FIFO
          // changes cannot disturb the frame in flight.
          shift_next = fifo_data;
          state_next = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_next = '0;
          if (bit_reg == DATA_LAST) begin
            bit_next   = '0;
            state_next = STOP;
          end else begin
            bit_next   = bit_reg + BIT_W'(1);
            shift_next = shift_reg >> 1;
          end
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_next = '0;
          if (bit_reg == STOP_LAST) begin
            bit_next   = '0;
            state_next = IDLE;
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic. tx is registered, so its next value follows the state
  // being entered; this puts the start bit on tx the cycle after the pop.
  always_comb begin
    tx_busy      = (state_reg != IDLE);
    tx_done_next = (state_reg == STOP) && (state_next == IDLE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx      = tx_reg;
  assign tx_done = tx_done_reg;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_drain
//   Two DUT instances (CLKS_PER_BIT=4; STOP_BITS=1 and STOP_BITS=2), each fed
//   by a queue-based FIFO model. Every byte written to a FIFO is also pushed to
//   that instance's expected-frame queue. A monitor decodes tx into frames and
//   pops/compares against the expected queue, and checks timing of the pop,
//   start bit, frame length, tx_busy and tx_done.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_drain;
  localparam int CPB = 4;
  localparam int DW  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_enable  [2];
  logic       fifo_empty [2];
  logic [7:0] fifo_data  [2];
  logic       fifo_rd    [2];
  logic       tx         [2];
  logic       tx_busy    [2];
  logic       tx_done    [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      uart_tx_fifo_drain #(
        .DATA_SIZE   (DW),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (gi + 1)
      ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .tx_enable (tx_enable[gi]),
        .fifo_empty(fifo_empty[gi]),
        .fifo_data (fifo_data[gi]),
        .fifo_rd   (fifo_rd[gi]),
        .tx        (tx[gi]),
        .tx_busy   (tx_busy[gi]),
        .tx_done   (tx_done[gi])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // ---------------- FIFO model and expected-frame scoreboard ----------------
  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  logic [7:0] eq0[$];
  logic [7:0] eq1[$];

  function automatic int fsize(input int i);
    return (i == 0) ? fq0.size() : fq1.size();
  endfunction

  function automatic int esize(input int i);
    return (i == 0) ? eq0.size() : eq1.size();
  endfunction

  function automatic logic [7:0] epop(input int i);
    if (i == 0) return eq0.pop_front();
    return eq1.pop_front();
  endfunction

  // Head word is only meaningful while non-empty; garbage otherwise.
  task automatic refresh(input int i);
    if (i == 0) begin
      fifo_empty[0] = (fq0.size() == 0);
      fifo_data[0]  = (fq0.size() != 0) ? fq0[0] : 8'($urandom);
    end else begin
      fifo_empty[1] = (fq1.size() == 0);
      fifo_data[1]  = (fq1.size() != 0) ? fq1[0] : 8'($urandom);
    end
  endtask

  task automatic wr(input int i, input logic [7:0] b);
    if (i == 0) begin
      fq0.push_back(b);
      eq0.push_back(b);
    end else begin
      fq1.push_back(b);
      eq1.push_back(b);
    end
    refresh(i);
  endtask

  task automatic fpop(input int i);
    if (fsize(i) == 0) chk("pop_when_empty", 1, 0);
    else if (i == 0) void'(fq0.pop_front());
    else void'(fq1.pop_front());
    refresh(i);
  endtask

  // ---------------- Monitor ----------------
  int   cyc      [2] = '{0, 0};
  bit   in_fr    [2] = '{0, 0};
  int   fcnt     [2] = '{0, 0};
  logic samp     [2][64];
  bit   done_due [2] = '{0, 0};
  int   done_cnt [2] = '{0, 0};
  int   rd_cnt   [2] = '{0, 0};
  int   pop_cyc  [2] = '{-1000, -1000};
  int   end_cyc  [2] = '{-1000, -1000};
  int   last_gap [2] = '{0, 0};
  bit   busy_bad [2] = '{0, 0};
  bit   pend     [2] = '{0, 0};
  bit   pend_prev[2] = '{0, 0};

  // Pop strobe as seen by the FIFO at the rising edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) pend[i] = fifo_rd[i];
  end

  task automatic finish_frame(input int i);
    int nb;
    int bad;
    logic [7:0]  e;
    logic [7:0]  got;
    logic [15:0] pat;
    nb  = 1 + DW + (i + 1);
    bad = 0;
    for (int k = 0; k < DW; k++) got[k] = samp[i][(1 + k) * CPB + CPB / 2];
    if (esize(i) == 0) begin
      chk($sformatf("unexpected_frame_inst%0d", i), 1, 0);
    end else begin
      e   = epop(i);
      pat = '1;
      pat[0] = 1'b0;
      pat[8:1] = e;
      for (int j = 0; j < nb * CPB; j++) if (samp[i][j] !== pat[j / CPB]) bad++;
      $display("inst%0d frame: want=%02h got=%02h cycles=%0d", i, e, got, nb * CPB);
      chk($sformatf("frame_data_inst%0d", i), int'(got), int'(e));
      chk($sformatf("frame_shape_bad_cycles_inst%0d", i), bad, 0);
    end
    chk($sformatf("busy_in_frame_inst%0d", i), int'(busy_bad[i]), 0);
  endtask

  task automatic mon_step(input int i);
    int n;
    n = (1 + DW + (i + 1)) * CPB;
    cyc[i]++;
    if (reset) begin
      chk("reset_tx", int'(tx[i]), 1);
      chk("reset_busy", int'(tx_busy[i]), 0);
      chk("reset_done", int'(tx_done[i]), 0);
      in_fr[i]     = 1'b0;
      done_due[i]  = 1'b0;
      pend_prev[i] = 1'b0;
      return;
    end
    if (pend[i]) begin
      rd_cnt[i]++;
      pop_cyc[i] = cyc[i];
      if (pend_prev[i]) chk("rd_single_cycle", 1, 0);
    end
    pend_prev[i] = pend[i];
    if (done_due[i]) begin
      chk($sformatf("tx_done_pulse_inst%0d", i), int'(tx_done[i]), 1);
      if (tx_done[i]) done_cnt[i]++;
      done_due[i] = 1'b0;
    end else if (tx_done[i] !== 1'b0) begin
      chk($sformatf("tx_done_spurious_inst%0d", i), 1, 0);
    end
    if (!in_fr[i]) begin
      if (tx[i] == 1'b0) begin
        chk($sformatf("start_after_pop_inst%0d", i), cyc[i] - pop_cyc[i], 0);
        last_gap[i] = cyc[i] - end_cyc[i] - 1;
        in_fr[i]    = 1'b1;
        fcnt[i]     = 0;
        busy_bad[i] = 1'b0;
      end else if (tx_busy[i] !== 1'b0) begin
        chk($sformatf("busy_while_idle_inst%0d", i), 1, 0);
      end
    end
    if (in_fr[i]) begin
      samp[i][fcnt[i]] = tx[i];
      if (tx_busy[i] !== 1'b1) busy_bad[i] = 1'b1;
      fcnt[i]++;
      if (fcnt[i] == n) begin
        finish_frame(i);
        in_fr[i]    = 1'b0;
        done_due[i] = 1'b1;
        end_cyc[i]  = cyc[i];
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) if (pend[i]) fpop(i);
    for (int i = 0; i < 2; i++) mon_step(i);
  end

  // ---------------- Stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int k;
    k = 0;
    while (k < budget && !(fsize(i) == 0 && esize(i) == 0 && !tx_busy[i] &&
                           !in_fr[i] && !done_due[i])) begin
      step(1);
      k++;
    end
    if (k >= budget) chk($sformatf("wait_idle_timeout_inst%0d", i), 0, 1);
    step(2);
  endtask

  task automatic wait_busy(input int i, input int budget);
    int k;
    k = 0;
    while (k < budget && tx_busy[i] !== 1'b1) begin
      step(1);
      k++;
    end
    if (k >= budget) chk($sformatf("wait_busy_timeout_inst%0d", i), 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int d0;
    int bad;
    reset        = 1'b1;
    tx_enable[0] = 1'b1;
    tx_enable[1] = 1'b1;
    refresh(0);
    refresh(1);
    wr(0, 8'hA5);
    step(1);
    // Reset state, with a non-empty FIFO: no pop while in reset.
    chk("reset_fifo_rd", int'(fifo_rd[0]), 0);
    chk("reset_tx0", int'(tx[0]), 1);
    chk("reset_busy0", int'(tx_busy[0]), 0);
    chk("reset_done0", int'(tx_done[0]), 0);
    chk("reset_tx1", int'(tx[1]), 1);
    step(1);
    reset = 1'b0;
    wr(1, 8'h55);

    // Test 1: single frame 0xA5; test 6 runs alongside on the 2-stop instance.
    wait_idle(0, 200);
    chk("t1_done_cnt", done_cnt[0], 1);
    chk("t1_rd_cnt", rd_cnt[0], 1);
    wait_idle(1, 200);
    chk("t6_done_cnt", done_cnt[1], 1);
    chk("t6_rd_cnt", rd_cnt[1], 1);

    // Test 2: back-to-back frames with a one-cycle gap.
    d0 = done_cnt[0];
    r0 = rd_cnt[0];
    wr(0, 8'h00);
    wr(0, 8'hFF);
    wait_idle(0, 300);
    chk("t2_done_delta", done_cnt[0] - d0, 2);
    chk("t2_rd_delta", rd_cnt[0] - r0, 2);
    chk("t2_gap", last_gap[0], 1);
    chk("t2_fifo_empty", fsize(0), 0);

    // Test 3: empty FIFO for 100 cycles.
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (fifo_rd[0] !== 1'b0 || tx[0] !== 1'b1 || tx_busy[0] !== 1'b0 || tx_done[0] !== 1'b0)
        bad++;
    end
    chk("t3_idle_bad_cycles", bad, 0);

    // Test 4: enable gating.
    r0 = rd_cnt[0];
    tx_enable[0] = 1'b0;
    wr(0, 8'h3C);
    step(20);
    chk("t4_no_pop_disabled", rd_cnt[0] - r0, 0);
    chk("t4_fifo_held", fsize(0), 1);
    tx_enable[0] = 1'b1;
    #1;
    chk("t4_rd_on_enable", int'(fifo_rd[0]), 1);
    step(15);
    wr(0, 8'h11);
    tx_enable[0] = 1'b0;
    while (tx_busy[0] === 1'b1 && cyc[0] < 20000) step(1);
    step(30);
    chk("t4_single_pop", rd_cnt[0] - r0, 1);
    chk("t4_fifo_left", fsize(0), 1);
    tx_enable[0] = 1'b1;
    wait_idle(0, 300);

    // Test 5: reset during data bit 3 of 0x81; 0x42 must follow intact.
    r0 = rd_cnt[0];
    d0 = done_cnt[0];
    wr(0, 8'h81);
    wr(0, 8'h42);
    wait_busy(0, 50);
    step(17);
    reset = 1'b1;
    void'(epop(0));
    step(1);
    reset = 1'b0;
    wait_idle(0, 300);
    chk("t5_done_delta", done_cnt[0] - d0, 1);
    chk("t5_rd_delta", rd_cnt[0] - r0, 2);

    // Randomised traffic with enable toggling.
    for (int r = 0; r < 40; r++) begin
      wr($urandom_range(0, 1), 8'($urandom));
      if ($urandom_range(0, 3) == 0) tx_enable[0] = ~tx_enable[0];
      step($urandom_range(1, 40));
    end
    tx_enable[0] = 1'b1;
    tx_enable[1] = 1'b1;
    wait_idle(0, 8000);
    wait_idle(1, 8000);
    chk("end_pops_vs_frames0", rd_cnt[0], done_cnt[0] + 1);
    chk("end_pops_vs_frames1", rd_cnt[1], done_cnt[1]);
    chk("end_exp_empty0", esize(0), 0);
    chk("end_exp_empty1", esize(1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
